exe_cmd_driver: RTL and testbench

Initiator side of the execution-unit operand/result interface.
- Accepts ALU commands (opcode + two operands) from an upstream valid/ready port and buffers them in a small FIFO.
- Issues each command to the execution unit and holds the operands stable for the unit's result latency.
- Captures result, status, carry and error, and returns them on a downstream valid/ready response port.
- Sits between the instruction/test sequencer and the execution unit, one command in flight at a time.

---
 rtl/exe_cmd_driver.sv | 149 ++++++++++++++
 tb/tb_exe_cmd_driver.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/exe_cmd_driver.sv
// exe_cmd_driver: queues ALU commands, issues them to the exe unit one at a time and returns the responses
module exe_cmd_driver #(
    parameter int WIDTH   = 32,
    parameter int OPER_W  = 2,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rsn,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic [WIDTH-1:0]           i_cmd_argA,
    input  logic [WIDTH-1:0]           i_cmd_argB,
    input  logic [OPER_W-1:0]          i_cmd_oper,
    output logic [WIDTH-1:0]           o_argA,
    output logic [WIDTH-1:0]           o_argB,
    output logic [OPER_W-1:0]          o_oper,
    input  logic [WIDTH-1:0]           i_result,
    input  logic [3:0]                 i_status,
    input  logic                       i_carry,
    input  logic                       i_error,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [WIDTH-1:0]           o_rsp_result,
    output logic [3:0]                 o_rsp_status,
    output logic                       o_rsp_carry,
    output logic                       o_rsp_error,
    output logic                       o_busy,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [OPER_W-1:0] ALU_ADD  = OPER_W'(0);
    localparam logic [OPER_W-1:0] ALU_COMP = OPER_W'(1);
    localparam logic [OPER_W-1:0] ALU_CONV = OPER_W'(2);
    localparam logic [OPER_W-1:0] ALU_SET  = OPER_W'(3);
    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
    state_t state, state_d;
    logic [3:0] cnt, cnt_d;
    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [OPER_W-1:0] mem_op [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic push, pop, head_legal;
    logic [WIDTH-1:0] arg_a_d, arg_b_d, rsp_result_d;
    logic [OPER_W-1:0] oper_d;
    logic [3:0] rsp_status_d;
    logic rsp_carry_d, rsp_error_d, rsp_valid_d;

    assign o_cmd_ready = o_count != CW'(DEPTH);
    assign push        = i_cmd_valid && o_cmd_ready;
    assign head_legal  = mem_op[rd_ptr] inside {ALU_ADD, ALU_COMP, ALU_CONV, ALU_SET};
    assign o_busy      = state != IDLE;

    // command FIFO: registered occupancy, so a fresh entry is seen by the FSM one cycle later
    always_ff @(posedge i_clk) begin
        if (!i_rsn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (push) begin
                mem_a[wr_ptr]  <= i_cmd_argA;
                mem_b[wr_ptr]  <= i_cmd_argB;
                mem_op[wr_ptr] <= i_cmd_oper;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            o_count <= o_count + CW'(push) - CW'(pop);
        end
    end

    // issue/wait/hold sequencing; illegal opcodes skip the exe unit and answer with error
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        pop          = 1'b0;
        arg_a_d      = o_argA;
        arg_b_d      = o_argB;
        oper_d       = o_oper;
        rsp_result_d = o_rsp_result;
        rsp_status_d = o_rsp_status;
        rsp_carry_d  = o_rsp_carry;
        rsp_error_d  = o_rsp_error;
        rsp_valid_d  = o_rsp_valid;
        case (state)
            IDLE: if (o_count != '0) begin
                pop = 1'b1;
                if (head_legal) begin
                    arg_a_d = mem_a[rd_ptr];
                    arg_b_d = mem_b[rd_ptr];
                    oper_d  = mem_op[rd_ptr];
                    cnt_d   = 4'(LATENCY);
                    state_d = WAIT;
                end else begin
                    rsp_result_d = '0;
                    rsp_status_d = '0;
                    rsp_carry_d  = 1'b0;
                    rsp_error_d  = 1'b1;
                    rsp_valid_d  = 1'b1;
                    state_d      = HOLD;
                end
            end
            WAIT: if (cnt == '0) begin
                rsp_result_d = i_result;
                rsp_status_d = i_status;
                rsp_carry_d  = i_carry;
                rsp_error_d  = i_error;
                rsp_valid_d  = 1'b1;
                state_d      = HOLD;
            end else begin
                cnt_d = cnt - 1'b1;
            end
            HOLD: if (i_rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and registered exe-unit / response outputs
    always_ff @(posedge i_clk) begin
        if (!i_rsn) begin
            state        <= IDLE;
            cnt          <= '0;
            o_argA       <= '0;
            o_argB       <= '0;
            o_oper       <= '0;
            o_rsp_result <= '0;
            o_rsp_status <= '0;
            o_rsp_carry  <= 1'b0;
            o_rsp_error  <= 1'b0;
            o_rsp_valid  <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            o_argA       <= arg_a_d;
            o_argB       <= arg_b_d;
            o_oper       <= oper_d;
            o_rsp_result <= rsp_result_d;
            o_rsp_status <= rsp_status_d;
            o_rsp_carry  <= rsp_carry_d;
            o_rsp_error  <= rsp_error_d;
            o_rsp_valid  <= rsp_valid_d;
        end
    end
endmodule

// File: tb/tb_exe_cmd_driver.sv
// tb_exe_cmd_driver: directed checks of three driver builds (LATENCY 1, 0, 3) sharing one command stream
module tb_exe_cmd_driver;
    logic i_clk = 1'b0;
    logic i_rsn, i_cmd_valid, i_rsp_ready;
    logic [31:0] i_cmd_argA, i_cmd_argB;
    logic [2:0] i_cmd_oper;
    logic [31:0] argA [3], argB [3], result [3], rsp_result [3];
    logic [2:0] oper [3], count [3];
    logic [3:0] status [3], rsp_status [3];
    logic carry [3], rsp_valid [3], rsp_carry [3], rsp_error [3], busy [3], cmd_ready [3];
    logic saw_illegal = 1'b0;
    int tests = 0, fails = 0;

    always #5 i_clk = ~i_clk;

    function automatic logic [32:0] exe_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op == 3'd0 ? {1'b0, a} + {1'b0, b} : op == 3'd3 ? {1'b0, a} : {1'b0, a ^ b};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : (g == 1) ? 0 : 3;
        exe_cmd_driver #(.WIDTH(32), .OPER_W(3), .DEPTH(4), .LATENCY(L)) u_dut (
            .i_clk(i_clk), .i_rsn(i_rsn), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(cmd_ready[g]),
            .i_cmd_argA(i_cmd_argA), .i_cmd_argB(i_cmd_argB), .i_cmd_oper(i_cmd_oper),
            .o_argA(argA[g]), .o_argB(argB[g]), .o_oper(oper[g]),
            .i_result(result[g]), .i_status(status[g]), .i_carry(carry[g]), .i_error(1'b0),
            .o_rsp_valid(rsp_valid[g]), .i_rsp_ready(i_rsp_ready),
            .o_rsp_result(rsp_result[g]), .o_rsp_status(rsp_status[g]),
            .o_rsp_carry(rsp_carry[g]), .o_rsp_error(rsp_error[g]),
            .o_busy(busy[g]), .o_count(count[g])
        );
        assign {carry[g], result[g]} = exe_model(oper[g], argA[g], argB[g]);
        assign status[g] = result[g][3:0];
    end

    always @(posedge i_clk) if (oper[0] == 3'd4) saw_illegal <= 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        i_cmd_valid = 1'b1;
        i_cmd_oper  = op;
        i_cmd_argA  = a;
        i_cmd_argB  = b;
    endtask

    task automatic do_reset;
        i_cmd_valid = 1'b0;
        i_rsn = 1'b0;
        tick;
        i_rsn = 1'b1;
    endtask

    logic [2:0]  c_op  [6] = '{3'd0, 3'd0, 3'd4, 3'd0, 3'd3, 3'd0};
    logic [31:0] c_a   [6] = '{32'd1, 32'd3, 32'd9, 32'd5, 32'hFFFF_FFFF, 32'd10};
    logic [31:0] c_b   [6] = '{32'd2, 32'd4, 32'd9, 32'd6, 32'd0, 32'd20};
    logic [31:0] e_res [6] = '{32'd3, 32'd7, 32'd0, 32'd11, 32'hFFFF_FFFF, 32'd30};
    logic        e_err [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int idx, cyc, bad, stale;
        int t [6];
        logic acc;
        i_rsn = 1'b0; i_cmd_valid = 1'b0; i_cmd_oper = '0; i_cmd_argA = '0; i_cmd_argB = '0; i_rsp_ready = 1'b1;
        repeat (3) tick;
        check("rst_count", count[0], 0);
        check("rst_ready", cmd_ready[0], 1);
        check("rst_valid", rsp_valid[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_argA", argA[0], 0);
        check("rst_result", rsp_result[0], 0);
        i_rsn = 1'b1;
        drive(3'd0, 32'd5, 32'd7);
        tick;
        check("add_count1", count[0], 1);
        check("add_busy_pre", busy[0], 0);
        i_cmd_valid = 1'b0;
        tick;
        check("add_argA", argA[0], 5);
        check("add_argB", argB[0], 7);
        check("add_oper", oper[0], 0);
        check("add_busy_n", busy[0], 1);
        check("add_count0", count[0], 0);
        check("add_valid_n", rsp_valid[0], 0);
        tick;
        check("add_valid_n1", rsp_valid[0], 0);
        check("l0_valid_n1", rsp_valid[1], 1);
        check("l0_result", rsp_result[1], 12);
        tick;
        check("add_valid_n2", rsp_valid[0], 1);
        check("add_result", rsp_result[0], 12);
        check("add_error", rsp_error[0], 0);
        check("add_status", rsp_status[0], 4'hC);
        check("add_busy_n2", busy[0], 1);
        tick;
        check("add_valid_done", rsp_valid[0], 0);
        check("add_busy_done", busy[0], 0);
        check("add_retain", rsp_result[0], 12);
        tick;
        check("l3_valid_n4", rsp_valid[2], 1);
        check("l3_result", rsp_result[2], 12);

        do_reset;
        drive(3'd3, 32'hFFFF_FFFF, 32'd0);
        tick;
        i_cmd_valid = 1'b0;
        tick;
        check("set_argA", argA[2], 32'hFFFF_FFFF);
        check("set_l0_valid_n", rsp_valid[1], 0);
        tick;
        check("set_l0_valid_n1", rsp_valid[1], 1);
        check("set_l0_result", rsp_result[1], 32'hFFFF_FFFF);
        check("set_l0_status", rsp_status[1], 4'hF);
        check("set_l3_valid_n1", rsp_valid[2], 0);
        tick;
        tick;
        check("set_l3_valid_n3", rsp_valid[2], 0);
        tick;
        check("set_l3_valid_n4", rsp_valid[2], 1);
        check("set_l3_result", rsp_result[2], 32'hFFFF_FFFF);
        check("set_l3_carry", rsp_carry[2], 0);

        do_reset;
        i_rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(c_op[i], c_a[i], c_b[i]);
            tick;
        end
        check("full_count", count[0], 4);
        check("full_ready", cmd_ready[0], 0);
        drive(c_op[5], c_a[5], c_b[5]);
        bad = 0;
        repeat (10) begin
            tick;
            if (count[0] != 3'd4 || cmd_ready[0] || !rsp_valid[0] || rsp_result[0] != 32'd3 || argA[0] != 32'd1 || argB[0] != 32'd2) bad++;
        end
        check("bp_stable", bad, 0);
        check("bp_result", rsp_result[0], 3);
        i_rsp_ready = 1'b1;
        idx = 0;
        cyc = 0;
        while (idx < 6 && cyc < 200) begin
            if (rsp_valid[0]) begin
                check($sformatf("ord_res%0d", idx), rsp_result[0], e_res[idx]);
                check($sformatf("ord_err%0d", idx), rsp_error[0], e_err[idx]);
                t[idx] = cyc;
                idx++;
            end
            acc = i_cmd_valid && cmd_ready[0];
            tick;
            cyc++;
            if (acc) i_cmd_valid = 1'b0;
        end
        check("rsp_count", idx, 6);
        check("thru_illegal", t[2] - t[1], 2);
        check("thru_add", t[3] - t[2], 4);
        check("oper_never_illegal", saw_illegal, 0);

        do_reset;
        i_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(3'd0, 32'(i), 32'd1);
            tick;
        end
        i_cmd_valid = 1'b0;
        check("mid_l3_busy", busy[2], 1);
        check("mid_count", count[2], 3);
        check("mid_l1_valid", rsp_valid[0], 1);
        i_rsn = 1'b0;
        tick;
        i_rsn = 1'b1;
        check("mid_rst_count", count[2], 0);
        check("mid_rst_busy", busy[2], 0);
        check("mid_rst_valid", rsp_valid[0], 0);
        check("mid_rst_l1_busy", busy[0], 0);
        check("mid_rst_argA", argA[0], 0);
        i_rsp_ready = 1'b1;
        stale = 0;
        repeat (8) begin
            tick;
            if (rsp_valid[0] || rsp_valid[1] || rsp_valid[2]) stale++;
        end
        check("no_stale", stale, 0);

        do_reset;
        drive(3'd0, 32'd1, 32'd1);
        tick;
        drive(3'd0, 32'd2, 32'd2);
        tick;
        drive(3'd0, 32'd3, 32'd3);
        tick;
        i_cmd_valid = 1'b0;
        check("pp_count_a", count[0], 2);
        tick;
        check("pp_valid", rsp_valid[0], 1);
        check("pp_result", rsp_result[0], 2);
        tick;
        check("pp_count_b", count[0], 2);
        check("pp_idle", busy[0], 0);
        drive(3'd0, 32'd4, 32'd4);
        tick;
        i_cmd_valid = 1'b0;
        check("pp_count_c", count[0], 2);
        check("pp_argA", argA[0], 2);
        check("pp_busy", busy[0], 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
